cardinal_ring_input_port: RTL and testbench

//  Router-side input port that consumes the cardinal_nic network interface
//  (net_so/net_di/net_ri) or an upstream ring link. It buffers one packet per

---
 rtl/cardinal_ring_input_port_if.sv | 26 ++
 rtl/cardinal_ring_input_port.sv | 85 ++++++++
 tb/tb_cardinal_ring_input_port.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/cardinal_ring_input_port_if.sv
// Link bundle between an upstream sender/arbiter side (master) and a ring input port (slave).
// Packets are big-endian [0:N-1]: bit 0 is the VC, bit 1 the direction.
interface cardinal_ring_input_port_if #(
    parameter int unsigned PACKET_SIZE = 64,
    parameter int unsigned CNT_W       = 8
);
    logic                   polarity;
    logic                   si;
    logic                   ri;
    logic [0:PACKET_SIZE-1] di;
    logic                   req_local;
    logic                   req_fwd;
    logic                   grant;
    logic [0:PACKET_SIZE-1] pkt_out;
    logic [CNT_W-1:0]       drop_cnt;

    modport master (
        output polarity, si, di, grant,
        input  ri, req_local, req_fwd, pkt_out, drop_cnt
    );

    modport slave (
        input  polarity, si, di, grant,
        output ri, req_local, req_fwd, pkt_out, drop_cnt
    );
endinterface

// File: rtl/cardinal_ring_input_port.sv
// Ring router input port: one packet buffer per virtual channel, filled on VC[polarity]
// and drained towards the local or forward arbiter on VC[~polarity].
module cardinal_ring_input_port #(
    parameter int unsigned PACKET_SIZE = 64,
    parameter int unsigned HOP_MSB     = 8,
    parameter int unsigned HOP_LSB     = 15,
    parameter int unsigned CNT_W       = 8
) (
    input logic                       clk,
    input logic                       reset,
    cardinal_ring_input_port_if.slave port
);
    localparam int unsigned HopW = HOP_LSB - HOP_MSB + 1;

    typedef logic [0:PACKET_SIZE-1] pkt_t;
    typedef enum logic {StEmpty, StFull} vc_state_e;

    vc_state_e        st_q  [2];
    vc_state_e        st_d  [2];
    pkt_t             buf_q [2];
    pkt_t             buf_d [2];
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic            in_vc, out_vc;
    logic            accept, drop, out_full, req_local, req_fwd;
    pkt_t            out_pkt;
    logic [HopW-1:0] hop;

    assign in_vc    = port.polarity;
    assign out_vc   = ~port.polarity;
    assign out_full = (st_q[out_vc] == StFull);
    assign out_pkt  = buf_q[out_vc];
    assign hop      = out_pkt[HOP_MSB:HOP_LSB];

    assign port.ri  = (st_q[in_vc] == StEmpty);
    assign accept   = port.si & port.ri & (port.di[0] == in_vc);
    assign drop     = port.si & port.ri & (port.di[0] != in_vc);

    assign req_local      = out_full & (hop == '0);
    assign req_fwd        = out_full & (hop != '0);
    assign port.req_local = req_local;
    assign port.req_fwd   = req_fwd;
    assign port.drop_cnt  = drop_cnt_q;

    // in_vc and out_vc always differ, so accept and grant never touch the same buffer.
    always_comb begin
        st_d       = st_q;
        buf_d      = buf_q;
        drop_cnt_d = drop_cnt_q;
        if (accept) begin
            buf_d[in_vc] = port.di;
            st_d[in_vc]  = StFull;
        end
        if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
        if (port.grant && (req_local || req_fwd)) begin
            st_d[out_vc] = StEmpty;
        end
    end

    always_comb begin
        port.pkt_out = '0;
        if (req_fwd) begin
            port.pkt_out                   = out_pkt;
            port.pkt_out[HOP_MSB:HOP_LSB] = hop - HopW'(1);
        end else if (req_local) begin
            port.pkt_out = out_pkt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q[0]    <= StEmpty;
            st_q[1]    <= StEmpty;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
            drop_cnt_q <= '0;
        end else begin
            st_q       <= st_d;
            buf_q      <= buf_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end
endmodule

// File: tb/tb_cardinal_ring_input_port.sv
// Directed bench for cardinal_ring_input_port: vector table plus drop-saturation and
// mid-operation reset sequences.
module tb_cardinal_ring_input_port;
    typedef logic [0:63] pkt_t;

    typedef struct {
        logic       si;
        logic       vc;
        logic [7:0] hop;
        logic [7:0] pay;
        logic       grant;
        logic       e_ri;
        logic       e_loc;
        logic       e_fwd;
        logic       e_vc;
        logic [7:0] e_hop;
        logic [7:0] e_pay;
        logic [7:0] e_drop;
    } vec_t;

    logic clk;
    logic reset;
    logic pol_r;
    int   n_checks;
    int   n_fail;
    vec_t vecs [18];

    cardinal_ring_input_port_if #(.PACKET_SIZE(64), .CNT_W(8)) link ();

    cardinal_ring_input_port #(
        .PACKET_SIZE(64),
        .HOP_MSB    (8),
        .HOP_LSB    (15),
        .CNT_W      (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .port (link.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic pkt_t mk(input logic vc, input logic [7:0] hop, input logic [7:0] pay);
        pkt_t p;
        p        = '0;
        p[0]     = vc;
        p[8:15]  = hop;
        p[56:63] = pay;
        return p;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic ri, input logic loc, input logic fwd,
                              input pkt_t pkt, input logic [7:0] drop);
        check({tag, " ri"}, 64'(link.ri), 64'(ri));
        check({tag, " req_local"}, 64'(link.req_local), 64'(loc));
        check({tag, " req_fwd"}, 64'(link.req_fwd), 64'(fwd));
        check({tag, " pkt_out"}, link.pkt_out, pkt);
        check({tag, " drop_cnt"}, 64'(link.drop_cnt), 64'(drop));
    endtask

    // Drive inputs for the current phase, then settle before sampling.
    task automatic drive(input logic si, input pkt_t di, input logic grant);
        link.polarity = pol_r;
        link.si       = si;
        link.di       = di;
        link.grant    = grant;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        pol_r = ~pol_r;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        pol_r    = 1'b0;

        // si, vc, hop, pay, grant | ri, loc, fwd, out vc, out hop, out pay, drop
        vecs[0]  = '{0, 0, 8'd0, 8'h00, 0, 1, 0, 0, 0, 8'd0, 8'h00, 8'd0}; // pol0 idle
        vecs[1]  = '{0, 0, 8'd0, 8'h00, 0, 1, 0, 0, 0, 8'd0, 8'h00, 8'd0}; // pol1 idle
        vecs[2]  = '{1, 0, 8'd3, 8'hA5, 0, 1, 0, 0, 0, 8'd0, 8'h00, 8'd0}; // pol0 fill VC0
        vecs[3]  = '{0, 0, 8'd0, 8'h00, 1, 1, 0, 1, 0, 8'd2, 8'hA5, 8'd0}; // pol1 fwd, grant
        vecs[4]  = '{0, 0, 8'd0, 8'h00, 0, 1, 0, 0, 0, 8'd0, 8'h00, 8'd0}; // pol0 VC0 empty
        vecs[5]  = '{1, 1, 8'd0, 8'h3C, 0, 1, 0, 0, 0, 8'd0, 8'h00, 8'd0}; // pol1 fill VC1
        vecs[6]  = '{0, 0, 8'd0, 8'h00, 0, 1, 1, 0, 1, 8'd0, 8'h3C, 8'd0}; // pol0 local
        vecs[7]  = '{0, 0, 8'd0, 8'h00, 0, 0, 0, 0, 0, 8'd0, 8'h00, 8'd0}; // pol1 ri low
        vecs[8]  = '{0, 0, 8'd0, 8'h00, 0, 1, 1, 0, 1, 8'd0, 8'h3C, 8'd0}; // pol0 re-request
        vecs[9]  = '{1, 1, 8'd5, 8'h77, 0, 0, 0, 0, 0, 8'd0, 8'h00, 8'd0}; // pol1 si & ~ri
        vecs[10] = '{1, 0, 8'd1, 8'h11, 1, 1, 1, 0, 1, 8'd0, 8'h3C, 8'd0}; // pol0 fill+grant
        vecs[11] = '{0, 0, 8'd0, 8'h00, 1, 1, 0, 1, 0, 8'd0, 8'h11, 8'd0}; // pol1 fwd, grant
        vecs[12] = '{0, 0, 8'd0, 8'h00, 0, 1, 0, 0, 0, 8'd0, 8'h00, 8'd0}; // pol0 no dup
        vecs[13] = '{0, 0, 8'd0, 8'h00, 0, 1, 0, 0, 0, 8'd0, 8'h00, 8'd0}; // pol1 no dup
        vecs[14] = '{1, 1, 8'd2, 8'h00, 0, 1, 0, 0, 0, 8'd0, 8'h00, 8'd0}; // pol0 drop
        vecs[15] = '{0, 0, 8'd0, 8'h00, 0, 1, 0, 0, 0, 8'd0, 8'h00, 8'd1}; // pol1
        vecs[16] = '{0, 0, 8'd0, 8'h00, 1, 1, 0, 0, 0, 8'd0, 8'h00, 8'd1}; // pol0 stray grant
        vecs[17] = '{0, 0, 8'd0, 8'h00, 0, 1, 0, 0, 0, 8'd0, 8'h00, 8'd1}; // pol1

        // Reset held with a matching packet offered: nothing may be captured.
        reset = 1'b0;
        drive(1'b1, mk(1'b0, 8'd3, 8'hEE), 1'b0);
        check_outs("reset", 1'b1, 1'b0, 1'b0, '0, 8'd0);
        @(posedge clk);
        #1;
        link.polarity = 1'b1;
        link.di       = mk(1'b1, 8'd0, 8'hEE);
        #1;
        check_outs("reset pol1", 1'b1, 1'b0, 1'b0, '0, 8'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        for (int i = 0; i < 18; i++) begin
            pkt_t exp_pkt;
            exp_pkt = (vecs[i].e_loc || vecs[i].e_fwd) ?
                      mk(vecs[i].e_vc, vecs[i].e_hop, vecs[i].e_pay) : '0;
            drive(vecs[i].si, mk(vecs[i].vc, vecs[i].hop, vecs[i].pay), vecs[i].grant);
            check_outs($sformatf("vec%0d", i), vecs[i].e_ri, vecs[i].e_loc, vecs[i].e_fwd,
                       exp_pkt, vecs[i].e_drop);
            tick();
        end

        // 299 more wrong-VC packets take the counter from 1 through saturation.
        for (int i = 0; i < 299; i++) begin
            drive(1'b1, mk(~pol_r, 8'd2, 8'(i)), 1'b0);
            if (i == 253) check("drop_cnt 254", 64'(link.drop_cnt), 64'd254);
            tick();
        end
        drive(1'b0, '0, 1'b0);
        check_outs("saturated", 1'b1, 1'b0, 1'b0, '0, 8'd255);
        tick();

        // Fill both VCs, then reset asynchronously mid-cycle.
        drive(1'b1, mk(1'b0, 8'd4, 8'hC3), 1'b0);
        check("fill0 ri", 64'(link.ri), 64'd1);
        tick();
        drive(1'b1, mk(1'b1, 8'd0, 8'hD4), 1'b0);
        check("fill1 req_fwd", 64'(link.req_fwd), 64'd1);
        check("fill1 pkt_out", link.pkt_out, mk(1'b0, 8'd3, 8'hC3));
        tick();
        drive(1'b0, '0, 1'b0);
        check("both full ri", 64'(link.ri), 64'd0);
        check("both full req_local", 64'(link.req_local), 64'd1);
        reset = 1'b0;
        #1;
        check_outs("async reset", 1'b0 | 1'b1, 1'b0, 1'b0, '0, 8'd0);
        tick();
        reset = 1'b1;
        drive(1'b0, '0, 1'b0);
        check_outs("post reset pol1", 1'b1, 1'b0, 1'b0, '0, 8'd0);
        tick();
        drive(1'b1, mk(1'b0, 8'd2, 8'h5A), 1'b0);
        check_outs("post reset pol0", 1'b1, 1'b0, 1'b0, '0, 8'd0);
        tick();
        drive(1'b0, '0, 1'b1);
        check_outs("first pkt", 1'b1, 1'b0, 1'b1, mk(1'b0, 8'd1, 8'h5A), 8'd0);
        tick();
        drive(1'b0, '0, 1'b0);
        check_outs("after first pol0", 1'b1, 1'b0, 1'b0, '0, 8'd0);
        tick();
        drive(1'b0, '0, 1'b0);
        check_outs("after first pol1", 1'b1, 1'b0, 1'b0, '0, 8'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
